// File: rtl/reg_file.sv
// Multi-port register file: NUM_RS combinational read ports, one synchronous write
// port, optional hardwired-zero register 0 and asynchronous active-low clear.
module reg_file #(
  parameter int NUM_RS    = 3,
  parameter int ZERO_REG  = 1,
  parameter int NUM_REG   = 32,
  parameter int REG_WIDTH = 32
) (
  input  logic                                        clk_i,
  input  logic                                        arst_ni,
  input  logic [$clog2(NUM_REG)-1:0]                  rd_addr_i,
  input  logic [REG_WIDTH-1:0]                        rd_data_i,
  input  logic                                        rd_en_i,
  input  logic [NUM_RS-1:0][$clog2(NUM_REG)-1:0]      rs_addr_i,
  output logic [NUM_RS-1:0][REG_WIDTH-1:0]            rs_data_o
);

  localparam int AW = $clog2(NUM_REG);
  // One extra bit so the range check also works when NUM_REG is a power of two.
  localparam logic [AW:0] NREG = (AW + 1)'(NUM_REG);

  if (NUM_RS < 1 || NUM_REG < 2 || REG_WIDTH < 1) begin : g_param_err
    $error("reg_file: illegal parameters NUM_RS=%0d NUM_REG=%0d REG_WIDTH=%0d",
           NUM_RS, NUM_REG, REG_WIDTH);
  end

  logic [NUM_REG-1:0][REG_WIDTH-1:0] regs_q, regs_d;
  logic                              wr_ok;

  always_comb begin
    wr_ok = rd_en_i && ({1'b0, rd_addr_i} < NREG);
    if (ZERO_REG != 0 && rd_addr_i == '0) begin
      wr_ok = 1'b0;
    end
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[rd_addr_i] = rd_data_i;
    end
    // Keep the zero register constant so synthesis can drop its storage.
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads have no bypass: a same-cycle write shows up only after the edge.
  always_comb begin
    rs_data_o = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if ({1'b0, rs_addr_i[i]} < NREG) begin
        rs_data_o[i] = regs_q[rs_addr_i[i]];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Randomized and directed bench for reg_file: three instances (zero reg, plain reg 0,
// non-power-of-two depth) compared against an array-based reference model.
module tb_reg_file;

  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [AW-1:0]        wa;
  logic [31:0]          wd;
  logic                 we;
  logic [2:0][AW-1:0]   ra;
  logic [1:0][AW-1:0]   ra_np;
  logic [2:0][31:0]     rz, rnz;
  logic [1:0][31:0]     rnp;

  assign ra_np = ra[1:0];

  reg_file #(.NUM_RS(3), .ZERO_REG(1), .NUM_REG(32), .REG_WIDTH(32)) dut_z (
    .clk_i(clk), .arst_ni(rst_n), .rd_addr_i(wa), .rd_data_i(wd), .rd_en_i(we),
    .rs_addr_i(ra), .rs_data_o(rz));

  reg_file #(.NUM_RS(3), .ZERO_REG(0), .NUM_REG(32), .REG_WIDTH(32)) dut_nz (
    .clk_i(clk), .arst_ni(rst_n), .rd_addr_i(wa), .rd_data_i(wd), .rd_en_i(we),
    .rs_addr_i(ra), .rs_data_o(rnz));

  reg_file #(.NUM_RS(2), .ZERO_REG(1), .NUM_REG(20), .REG_WIDTH(32)) dut_np (
    .clk_i(clk), .arst_ni(rst_n), .rd_addr_i(wa), .rd_data_i(wd), .rd_en_i(we),
    .rs_addr_i(ra_np), .rs_data_o(rnp));

  logic [31:0] m_z  [32];
  logic [31:0] m_nz [32];
  logic [31:0] m_np [20];

  int checks = 0;
  int passed = 0;

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      m_z[i]  = '0;
      m_nz[i] = '0;
      if (i < 20) m_np[i] = '0;
    end
  endtask

  task automatic model_write(input int a, input logic [31:0] d);
    m_nz[a] = d;
    if (a != 0) m_z[a] = d;
    if (a != 0 && a < 20) m_np[a] = d;
  endtask

  function automatic logic [31:0] exp_z(input int a);
    return (a == 0) ? 32'h0 : m_z[a];
  endfunction

  function automatic logic [31:0] exp_nz(input int a);
    return m_nz[a];
  endfunction

  function automatic logic [31:0] exp_np(input int a);
    return (a == 0 || a >= 20) ? 32'h0 : m_np[a];
  endfunction

  task automatic wr_cycle(input int a, input logic [31:0] d, input logic en);
    @(negedge clk);
    wa = AW'(a);
    wd = d;
    we = en;
    @(posedge clk);
    if (en && rst_n) model_write(a, d);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    we = 1'b0;
    wa = '0;
    wd = '0;
    ra = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    for (int a = 0; a < 32; a++) begin
      ra = {AW'(a), AW'(a), AW'(a)};
      #1;
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (rz[p] !== 32'h0) $display("FAIL reset_z a=%0d p=%0d got %h exp 0", a, p, rz[p]);
        else passed++;
        checks++;
        if (rnz[p] !== 32'h0) $display("FAIL reset_nz a=%0d p=%0d got %h exp 0", a, p, rnz[p]);
        else passed++;
      end
    end
    // Asynchronous clear in the middle of a cycle.
    wr_cycle(5, 32'hDEADBEEF, 1'b1);
    ra = {AW'(5), AW'(5), AW'(5)};
    #1;
    checks++;
    if (rz[0] !== 32'hDEADBEEF) $display("FAIL pre_reset_r5 got %h exp deadbeef", rz[0]);
    else passed++;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (rz[p] !== 32'h0) $display("FAIL async_clear_z p=%0d got %h exp 0", p, rz[p]);
      else passed++;
      checks++;
      if (rnz[p] !== 32'h0) $display("FAIL async_clear_nz p=%0d got %h exp 0", p, rnz[p]);
      else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    for (int a = 0; a < 32; a++) begin
      ra[0] = AW'(a);
      #1;
      checks++;
      if (rnz[0] !== 32'h0) $display("FAIL post_reset_nz a=%0d got %h exp 0", a, rnz[0]);
      else passed++;
    end
  endtask

  task automatic test_reset_blocks_write();
    @(negedge clk);
    rst_n = 1'b0;
    wa = AW'(10);
    wd = 32'h55555555;
    we = 1'b1;
    ra = {AW'(10), AW'(10), AW'(10)};
    @(posedge clk);
    #1;
    checks++;
    if (rnz[0] !== 32'h0) $display("FAIL write_in_reset got %h exp 0", rnz[0]);
    else passed++;
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    clear_model();
    #1;
    checks++;
    if (rnz[1] !== 32'h0) $display("FAIL after_release got %h exp 0", rnz[1]);
    else passed++;
    wr_cycle(10, 32'h77777777, 1'b1);
    checks++;
    if (rz[2] !== 32'h77777777) $display("FAIL first_write_after_reset got %h exp 77777777", rz[2]);
    else passed++;
  endtask

  task automatic test_basic_write();
    wr_cycle(7, 32'h12345678, 1'b1);
    ra = {AW'(7), AW'(7), AW'(7)};
    #1;
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (rz[p] !== 32'h12345678) $display("FAIL basic_r7 p=%0d got %h exp 12345678", p, rz[p]);
      else passed++;
    end
    ra[1] = AW'(8);
    #1;
    checks++;
    if (rz[1] !== 32'h0) $display("FAIL basic_r8 got %h exp 0", rz[1]);
    else passed++;
    checks++;
    if (rz[0] !== 32'h12345678) $display("FAIL basic_r7_other_port got %h exp 12345678", rz[0]);
    else passed++;
  endtask

  task automatic test_zero_reg();
    wr_cycle(0, 32'hFFFFFFFF, 1'b1);
    ra = '0;
    #1;
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (rz[p] !== 32'h0) $display("FAIL zero_reg_z p=%0d got %h exp 0", p, rz[p]);
      else passed++;
      checks++;
      if (rnz[p] !== 32'hFFFFFFFF) $display("FAIL zero_reg_nz p=%0d got %h exp ffffffff", p, rnz[p]);
      else passed++;
    end
    checks++;
    if (rnp[0] !== 32'h0) $display("FAIL zero_reg_np got %h exp 0", rnp[0]);
    else passed++;
  endtask

  task automatic test_read_during_write();
    wr_cycle(3, 32'h11111111, 1'b1);
    @(negedge clk);
    wa = AW'(3);
    wd = 32'h22222222;
    we = 1'b1;
    ra = {AW'(3), AW'(3), AW'(3)};
    #1;
    checks++;
    if (rz[0] !== 32'h11111111) $display("FAIL rdw_before got %h exp 11111111", rz[0]);
    else passed++;
    @(posedge clk);
    model_write(3, 32'h22222222);
    #1;
    we = 1'b0;
    checks++;
    if (rz[0] !== 32'h22222222) $display("FAIL rdw_after got %h exp 22222222", rz[0]);
    else passed++;
  endtask

  task automatic test_disabled_write();
    wr_cycle(9, 32'hA5A5A5A5, 1'b0);
    ra = {AW'(9), AW'(9), AW'(9)};
    #1;
    checks++;
    if (rz[0] !== 32'h0) $display("FAIL disabled_z got %h exp 0", rz[0]);
    else passed++;
    checks++;
    if (rnz[2] !== 32'h0) $display("FAIL disabled_nz got %h exp 0", rnz[2]);
    else passed++;
  endtask

  task automatic test_out_of_range();
    wr_cycle(5, 32'h0BADF00D, 1'b1);
    wr_cycle(21, 32'hCAFEBABE, 1'b1);
    ra = {AW'(21), AW'(5), AW'(21)};
    #1;
    checks++;
    if (rnp[0] !== 32'h0) $display("FAIL oor_read got %h exp 0", rnp[0]);
    else passed++;
    checks++;
    if (rnp[1] !== 32'h0BADF00D) $display("FAIL oor_alias got %h exp 0badf00d", rnp[1]);
    else passed++;
    checks++;
    if (rz[2] !== 32'hCAFEBABE) $display("FAIL oor_full_depth got %h exp cafebabe", rz[2]);
    else passed++;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, 31));
      wd = $urandom;
      for (int p = 0; p < 3; p++) begin
        ra[p] = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
      end
      #1;
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (rz[p] !== exp_z(int'(ra[p])))
          $display("FAIL rand_z cyc=%0d p=%0d a=%0d got %h exp %h", cyc, p, ra[p], rz[p], exp_z(int'(ra[p])));
        else passed++;
        checks++;
        if (rnz[p] !== exp_nz(int'(ra[p])))
          $display("FAIL rand_nz cyc=%0d p=%0d a=%0d got %h exp %h", cyc, p, ra[p], rnz[p], exp_nz(int'(ra[p])));
        else passed++;
        if (p < 2) begin
          checks++;
          if (rnp[p] !== exp_np(int'(ra[p])))
            $display("FAIL rand_np cyc=%0d p=%0d a=%0d got %h exp %h", cyc, p, ra[p], rnp[p], exp_np(int'(ra[p])));
          else passed++;
        end
      end
      @(posedge clk);
      if (we) model_write(int'(wa), wd);
      #1;
    end
    we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_blocks_write();
    test_basic_write();
    test_zero_reg();
    test_read_during_write();
    test_disabled_write();
    test_out_of_range();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
